// File: rtl/ds_pkg.sv
// Shared definitions for the IEEE 1355 data-strobe receiver: control codes,
// NULL hunt pattern, character field widths and the character FSM encoding.
package ds_pkg;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned CTRL_BITS = 2;

   localparam logic [1:0] CTRL_FCC  = 2'b00;
   localparam logic [1:0] CTRL_EOP1 = 2'b01;
   localparam logic [1:0] CTRL_EOP2 = 2'b10;
   localparam logic [1:0] CTRL_ESC  = 2'b11;

   // Oldest bit in the MSB: F,c0,c1 of ESC then P,F,c0,c1 of FCC with P forced to 0.
   localparam logic [6:0] NULL_HUNT_PATTERN = 7'b1110100;

   typedef enum logic [1:0] {
      HUNT  = 2'b00,
      RUN   = 2'b01,
      ERROR = 2'b10
   } rx_state_e;

   // Odd parity across previous payload, P and F; prev_par is the XOR of the previous payload.
   function automatic logic parity_ok(input logic prev_par, input logic p_bit, input logic f_bit);
      return prev_par ^ p_bit ^ f_bit;
   endfunction

endpackage

// File: rtl/ds_bit_recover.sv
// DS bit recovery: synchronizes the data and strobe lines into clk and
// reports a one-cycle bit_valid whenever the D xor S state changes.
module ds_bit_recover #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   input  logic s_i,
   output logic bit_valid_o,
   output logic bit_val_o
);

   logic [SYNC_STAGES-1:0] d_sync_q;
   logic [SYNC_STAGES-1:0] s_sync_q;
   logic                   x_prev_q;
   logic                   d_s;
   logic                   s_s;

   assign d_s = d_sync_q[SYNC_STAGES-1];
   assign s_s = s_sync_q[SYNC_STAGES-1];

   // Synchronizer chains and the previous D xor S state for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_sync_q <= '0;
         s_sync_q <= '0;
         x_prev_q <= 1'b0;
      end else begin
         d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], d_i};
         s_sync_q <= {s_sync_q[SYNC_STAGES-2:0], s_i};
         x_prev_q <= d_s ^ s_s;
      end
   end

   assign bit_valid_o = (d_s ^ s_s) != x_prev_q;
   assign bit_val_o   = d_s;

endmodule

// File: rtl/ds_rx.sv
// IEEE 1355 DS receiver: hunts for the first NULL, then decodes data and
// control characters with parity, escape and disconnect checking.
module ds_rx
   import ds_pkg::*;
#(
   parameter int unsigned DISC_TIMEOUT = 64,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d_in,
   input  logic       s_in,
   output logic [8:0] rx_data,
   output logic       rx_valid,
   output logic       rx_fct,
   output logic       null_rcvd,
   output logic       link_up,
   output logic       parity_err,
   output logic       esc_err,
   output logic       disc_err
);

   localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS + 1);
   localparam logic [3:0] LAST_CTRL  = 4'(CTRL_BITS + 1);
   localparam logic [7:0] DISC_LIMIT = 8'(DISC_TIMEOUT - 1);

   logic       bit_valid;
   logic       bit_val;

   rx_state_e  state_q;
   logic [5:0] win_q;
   logic [3:0] bit_cnt_q;
   logic       p_q;
   logic       is_ctrl_q;
   logic [7:0] pay_q;
   logic       prev_par_q;
   logic       esc_pending_q;
   logic [7:0] disc_cnt_q;

   logic [8:0] rx_data_q;
   logic       rx_valid_q;
   logic       rx_fct_q;
   logic       null_rcvd_q;
   logic       link_up_q;
   logic       parity_err_q;
   logic       esc_err_q;
   logic       disc_err_q;

   logic [6:0] win_d;
   logic [2:0] pay_idx;
   logic [7:0] pay_d;
   logic       last_bit;
   logic       disc_hit;

   ds_bit_recover #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_bit_recover (
      .clk         (clk),
      .rst         (rst),
      .d_i         (d_in),
      .s_i         (s_in),
      .bit_valid_o (bit_valid),
      .bit_val_o   (bit_val)
   );

   // Next hunt window, payload with the current bit inserted, and end-of-char/timeout detection.
   always_comb begin
      win_d          = {win_q, bit_val};
      pay_idx        = bit_cnt_q[2:0] - 3'd2;
      pay_d          = pay_q;
      pay_d[pay_idx] = bit_val;
      last_bit       = is_ctrl_q ? (bit_cnt_q == LAST_CTRL) : (bit_cnt_q == LAST_DATA);
      disc_hit       = !bit_valid && (disc_cnt_q == DISC_LIMIT);
   end

   // Character FSM with registered strobes; errors always detour through ERROR for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= HUNT;
         win_q         <= 6'd0;
         bit_cnt_q     <= 4'd0;
         p_q           <= 1'b0;
         is_ctrl_q     <= 1'b0;
         pay_q         <= 8'd0;
         prev_par_q    <= 1'b0;
         esc_pending_q <= 1'b0;
         disc_cnt_q    <= 8'd0;
         rx_data_q     <= 9'h000;
         rx_valid_q    <= 1'b0;
         rx_fct_q      <= 1'b0;
         null_rcvd_q   <= 1'b0;
         link_up_q     <= 1'b0;
         parity_err_q  <= 1'b0;
         esc_err_q     <= 1'b0;
         disc_err_q    <= 1'b0;
      end else begin
         rx_valid_q   <= 1'b0;
         rx_fct_q     <= 1'b0;
         null_rcvd_q  <= 1'b0;
         parity_err_q <= 1'b0;
         esc_err_q    <= 1'b0;
         disc_err_q   <= 1'b0;

         // Holds cycles elapsed since the last edge; only advances while in RUN.
         if (bit_valid) begin
            disc_cnt_q <= 8'd1;
         end else if (state_q == RUN) begin
            disc_cnt_q <= disc_cnt_q + 8'd1;
         end else begin
            disc_cnt_q <= 8'd0;
         end

         case (state_q)
            HUNT: begin
               if (bit_valid) begin
                  win_q <= win_d[5:0];
                  if (win_d == NULL_HUNT_PATTERN) begin
                     null_rcvd_q   <= 1'b1;
                     link_up_q     <= 1'b1;
                     prev_par_q    <= 1'b0;
                     bit_cnt_q     <= 4'd0;
                     esc_pending_q <= 1'b0;
                     state_q       <= RUN;
                  end
               end
            end

            RUN: begin
               if (disc_hit) begin
                  disc_err_q <= 1'b1;
                  link_up_q  <= 1'b0;
                  state_q    <= ERROR;
               end else if (bit_valid) begin
                  case (bit_cnt_q)
                     4'd0: begin
                        p_q       <= bit_val;
                        bit_cnt_q <= 4'd1;
                     end
                     4'd1: begin
                        if (!parity_ok(prev_par_q, p_q, bit_val)) begin
                           parity_err_q <= 1'b1;
                           link_up_q    <= 1'b0;
                           state_q      <= ERROR;
                        end else begin
                           is_ctrl_q <= bit_val;
                           bit_cnt_q <= 4'd2;
                        end
                     end
                     default: begin
                        pay_q <= pay_d;
                        if (!last_bit) begin
                           bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else begin
                           bit_cnt_q  <= 4'd0;
                           prev_par_q <= is_ctrl_q ? ^pay_d[1:0] : ^pay_d;
                           if (esc_pending_q) begin
                              esc_pending_q <= 1'b0;
                              if (is_ctrl_q && (pay_d[1:0] == CTRL_FCC)) begin
                                 null_rcvd_q <= 1'b1;
                              end else begin
                                 esc_err_q <= 1'b1;
                                 link_up_q <= 1'b0;
                                 state_q   <= ERROR;
                              end
                           end else if (!is_ctrl_q) begin
                              rx_data_q  <= {1'b0, pay_d};
                              rx_valid_q <= 1'b1;
                           end else begin
                              case (pay_d[1:0])
                                 CTRL_FCC: rx_fct_q <= 1'b1;
                                 CTRL_EOP1, CTRL_EOP2: begin
                                    rx_data_q  <= {1'b1, 6'b000000, pay_d[1:0]};
                                    rx_valid_q <= 1'b1;
                                 end
                                 CTRL_ESC: esc_pending_q <= 1'b1;
                                 default:  esc_pending_q <= esc_pending_q;
                              endcase
                           end
                        end
                     end
                  endcase
               end
            end

            ERROR: begin
               win_q         <= 6'd0;
               bit_cnt_q     <= 4'd0;
               esc_pending_q <= 1'b0;
               link_up_q     <= 1'b0;
               state_q       <= HUNT;
            end

            default: begin
               link_up_q <= 1'b0;
               state_q   <= HUNT;
            end
         endcase
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_fct     = rx_fct_q;
   assign null_rcvd  = null_rcvd_q;
   assign link_up    = link_up_q;
   assign parity_err = parity_err_q;
   assign esc_err    = esc_err_q;
   assign disc_err   = disc_err_q;

endmodule

// File: tb/tb_ds_rx.sv
// Scoreboard bench for ds_rx: DS-encodes characters one bit per 4 clocks and
// checks every receiver strobe for kind, data and exact cycle.
module tb_ds_rx;

   localparam int DISC_TIMEOUT = 64;
   localparam int SYNC_STAGES  = 2;

   localparam int EV_VALID = 0;
   localparam int EV_FCT   = 1;
   localparam int EV_NULL  = 2;
   localparam int EV_PERR  = 3;
   localparam int EV_EERR  = 4;
   localparam int EV_DERR  = 5;

   localparam int AT_NONE = 0;
   localparam int AT_F    = 1;
   localparam int AT_LAST = 2;

   typedef struct {
      int         kind;
      logic [8:0] data;
      int         cyc;
   } ev_t;

   ev_t sb_q[$];

   logic       clk = 1'b0;
   logic       rst;
   logic       d_in;
   logic       s_in;
   logic [8:0] rx_data;
   logic       rx_valid;
   logic       rx_fct;
   logic       null_rcvd;
   logic       link_up;
   logic       parity_err;
   logic       esc_err;
   logic       disc_err;

   int   n_chk        = 0;
   int   n_fail       = 0;
   int   cyc          = 0;
   int   last_drv_cyc = 0;
   logic line_x       = 1'b0;
   logic tb_prev_par  = 1'b0;

   ds_rx #(
      .DISC_TIMEOUT (DISC_TIMEOUT),
      .SYNC_STAGES  (SYNC_STAGES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .d_in       (d_in),
      .s_in       (s_in),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_fct     (rx_fct),
      .null_rcvd  (null_rcvd),
      .link_up    (link_up),
      .parity_err (parity_err),
      .esc_err    (esc_err),
      .disc_err   (disc_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Strobe appears SYNC_STAGES+1 clocks after the bit is driven on a falling edge.
   task automatic push_ev(input int kind, input logic [8:0] data);
      sb_q.push_back('{kind, data, cyc + SYNC_STAGES + 1});
   endtask

   task automatic send_bit(input logic b);
      line_x       = ~line_x;
      d_in         = b;
      s_in         = b ^ line_x;
      last_drv_cyc = cyc;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_char(input logic ctrl, input logic [7:0] pay, input logic p_inv,
                            input int kind, input int at, input logic [8:0] data);
      logic p;
      int   nb;
      p = 1'b1 ^ tb_prev_par ^ ctrl ^ p_inv;
      send_bit(p);
      if (at == AT_F) push_ev(kind, data);
      send_bit(ctrl);
      nb = ctrl ? 2 : 8;
      for (int i = 0; i < nb; i++) begin
         if (at == AT_LAST && i == nb - 1) push_ev(kind, data);
         send_bit(pay[i]);
      end
      tb_prev_par = ctrl ? ^pay[1:0] : ^pay;
   endtask

   task automatic send_null();
      send_char(1'b1, 8'h03, 1'b0, EV_NULL, AT_NONE, 9'h000);
      send_char(1'b1, 8'h00, 1'b0, EV_NULL, AT_LAST, 9'h000);
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
      check_val("sb_drain", sb_q.size(), 0);
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin : mon
      int  n;
      int  kind;
      ev_t e;
      if (rst === 1'b0) begin
         n = int'(rx_valid) + int'(rx_fct) + int'(null_rcvd)
           + int'(parity_err) + int'(esc_err) + int'(disc_err);
         if (n != 0) begin
            check_val("one_strobe_per_cycle", n, 1);
            kind = rx_valid   ? EV_VALID :
                   rx_fct     ? EV_FCT   :
                   null_rcvd  ? EV_NULL  :
                   parity_err ? EV_PERR  :
                   esc_err    ? EV_EERR  : EV_DERR;
            if (sb_q.size() == 0) begin
               check_val("unexpected_strobe", kind, 32'hFFFF_FFFF);
            end else begin
               e = sb_q.pop_front();
               check_val("strobe_kind", kind, e.kind);
               check_val("strobe_cycle", cyc, e.cyc);
               if (kind == EV_VALID) check_val("rx_data", rx_data, e.data);
               if (kind == EV_NULL)  check_val("link_up_on_null", link_up, 1);
               if (kind >= EV_PERR)  check_val("link_up_on_err", link_up, 0);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] data_tbl [4];
      data_tbl[0] = 8'hA5;
      data_tbl[1] = 8'h00;
      data_tbl[2] = 8'hFF;
      data_tbl[3] = 8'h5A;

      rst  = 1'b1;
      d_in = 1'b0;
      s_in = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_rx_data", rx_data, 9'h000);
      check_val("reset_strobes", {rx_valid, rx_fct, null_rcvd, parity_err, esc_err, disc_err}, 6'b0);
      check_val("reset_link_up", link_up, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // NULL acquisition from HUNT
      send_null();
      wait_drain(40);
      check_val("link_up_after_null", link_up, 1);

      // Data characters
      for (int i = 0; i < 4; i++) begin
         send_char(1'b0, data_tbl[i], 1'b0, EV_VALID, AT_LAST, {1'b0, data_tbl[i]});
      end
      wait_drain(40);

      // NULL while running, EOP1, standalone FCC
      send_null();
      send_char(1'b1, 8'h01, 1'b0, EV_VALID, AT_LAST, 9'h101);
      send_char(1'b1, 8'h00, 1'b0, EV_FCT, AT_LAST, 9'h000);
      wait_drain(40);
      check_val("link_up_after_fct", link_up, 1);

      // Parity error on 0x3C, then re-acquire
      send_char(1'b0, 8'h3C, 1'b1, EV_PERR, AT_F, 9'h000);
      wait_drain(40);
      check_val("link_up_after_perr", link_up, 0);
      send_null();
      wait_drain(40);
      check_val("link_up_reacquired", link_up, 1);

      // ESC followed by EOP2
      send_char(1'b1, 8'h03, 1'b0, EV_EERR, AT_NONE, 9'h000);
      send_char(1'b1, 8'h02, 1'b0, EV_EERR, AT_LAST, 9'h000);
      wait_drain(40);
      check_val("link_up_after_eerr", link_up, 0);

      // Disconnect timeout measured from the last edge
      send_null();
      sb_q.push_back('{EV_DERR, 9'h000, last_drv_cyc + SYNC_STAGES + DISC_TIMEOUT});
      wait_drain(200);
      check_val("link_up_after_disc", link_up, 0);

      // Reset in the middle of a data character
      send_null();
      wait_drain(40);
      check_val("link_up_before_rst", link_up, 1);
      send_bit(1'b1 ^ tb_prev_par);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst = 1'b1;
      #1;
      check_val("rst_async_link_up", link_up, 0);
      check_val("rst_async_outs", {rx_data, rx_valid, rx_fct, null_rcvd, parity_err, esc_err, disc_err}, 15'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_val("link_up_after_rst", link_up, 0);
      check_val("sb_empty_end", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
